// File: rtl/mac_share_arb.sv
// Purpose : shares one free-running A*B+C datapath between N requesters, routes results back by tag.
// Latency : handshake in cycle n -> rsp_valid in cycle n+LAT+1 (n+4 by default), issue order kept.
// Backpres: one-hot combinational req_ready, one issue per cycle; responses cannot be stalled.
//
// Ports
//   C, RST                  clock (posedge) and asynchronous active-high reset
//   req_valid/req_ready     per-requester handshake; req_ready is a one-hot grant
//   req_a/req_b/req_c       packed operands, requester i at [i*P +: P]
//   mac_a/mac_b/mac_c       registered operands to the shared datapath
//   mac_data                datapath result, LAT cycles after operands are presented
//   rsp_valid/rsp_id        one-hot result strobe and owning requester index
//   rsp_data                datapath result passthrough, valid while |rsp_valid
//   flush_req/flush_done    stop issuing and drain the tag pipe / drained indication
//   busy                    any request pending or any op in flight
//
// Build option: MAC_ARB_FIXPRIO_EN selects fixed priority (lowest index wins) instead of
// round-robin; the round-robin pointer is then not built.

module mac_share_arb #(
   parameter int P   = 8,
   parameter int N   = 4,
   parameter int LAT = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic              C,
   input  logic              RST,
   input  logic [N-1:0]      req_valid,
   output logic [N-1:0]      req_ready,
   input  logic [N*P-1:0]    req_a,
   input  logic [N*P-1:0]    req_b,
   input  logic [N*P-1:0]    req_c,
   output logic [P-1:0]      mac_a,
   output logic [P-1:0]      mac_b,
   output logic [P-1:0]      mac_c,
   input  logic [2*P-1:0]    mac_data,
   output logic [N-1:0]      rsp_valid,
   output logic [IW-1:0]     rsp_id,
   output logic [2*P-1:0]    rsp_data,
   input  logic              flush_req,
   output logic              flush_done,
   output logic              busy
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef struct packed {
      logic          vld;
      logic [IW-1:0] id;
   } tag_t;

   logic [1:0]    state_q;
   logic          grant_vld;
   logic [IW-1:0] grant_idx;
   logic          can_issue;
   logic          issue;
   logic          tag_any;
   tag_t          tag_q [LAT+1];

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
`ifdef MAC_ARB_FIXPRIO_EN
   // Scan downwards so the lowest valid index is the last (winning) write.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = IW'(i);
         end
      end
   end
`else
   logic [IW-1:0] rr_ptr;

   // First valid requester at or after rr_ptr, wrapping modulo N.
   always_comb begin
      int            j;
      logic [IW-1:0] j_idx;
      j         = 0;
      j_idx     = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         j_idx = IW'(j);
         if (!grant_vld && req_valid[j_idx]) begin
            grant_vld = 1'b1;
            grant_idx = j_idx;
         end
      end
   end

   always_ff @(posedge C or posedge RST) begin
      if (RST) begin
         rr_ptr <= '0;
      end else if (issue) begin
         rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
      end
   end
`endif

   // RST gates the grant so nothing can be accepted while reset is held.
   assign can_issue = (state_q == ST_RUN) && !flush_req && !RST;
   assign issue     = can_issue && grant_vld;

   always_comb begin
      req_ready = '0;
      if (issue) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Operand registers: hold their last value when nothing issues
   // ------------------------------------------------------------------
   always_ff @(posedge C or posedge RST) begin
      if (RST) begin
         mac_a <= '0;
         mac_b <= '0;
         mac_c <= '0;
      end else if (issue) begin
         mac_a <= req_a[int'(grant_idx)*P +: P];
         mac_b <= req_b[int'(grant_idx)*P +: P];
         mac_c <= req_c[int'(grant_idx)*P +: P];
      end
   end

   // ------------------------------------------------------------------
   // Tag pipe: stage 0 lines up with mac_*, stage LAT with mac_data.
   // Clearing it on reset is what keeps stale datapath contents from
   // ever being reported as a response.
   // ------------------------------------------------------------------
   always_ff @(posedge C or posedge RST) begin
      if (RST) begin
         for (int i = 0; i <= LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0].vld <= issue;
         tag_q[0].id  <= issue ? grant_idx : '0;
         for (int i = 1; i <= LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_comb begin
      tag_any = 1'b0;
      for (int i = 0; i <= LAT; i++) begin
         tag_any = tag_any | tag_q[i].vld;
      end
   end

   // ------------------------------------------------------------------
   // Flush FSM
   // ------------------------------------------------------------------
   always_ff @(posedge C or posedge RST) begin
      if (RST) begin
         state_q <= ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:   if (flush_req) state_q <= ST_DRAIN;
            ST_DRAIN: if (!tag_any)  state_q <= ST_DONE;
            ST_DONE:  if (!flush_req) state_q <= ST_RUN;
            default:  state_q <= ST_RUN;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Response decode
   // ------------------------------------------------------------------
   always_comb begin
      rsp_valid = '0;
      rsp_id    = '0;
      if (tag_q[LAT].vld) begin
         rsp_valid[tag_q[LAT].id] = 1'b1;
         rsp_id                   = tag_q[LAT].id;
      end
   end

   assign rsp_data   = mac_data;
   assign flush_done = (state_q == ST_DONE);
   assign busy       = (|req_valid) | tag_any;

endmodule
